// File: rtl/dnn_batch_sched.sv
// Batch controller for the fix10 sigmoid inference engine: sequences engine
// reset/start per image, scans the 10 outputs for an argmax, and hands results downstream.
module dnn_batch_sched #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned BATCH_W    = 8,
  parameter int unsigned TMO_W      = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         batch_start,
  input  logic [BATCH_W-1:0]           batch_count,
  input  logic                         batch_abort,
  output logic                         busy,
  output logic                         batch_done,
  output logic                         err_timeout,
  output logic [BATCH_W-1:0]           img_idx,
  output logic                         eng_reset,
  output logic                         eng_start,
  input  logic                         eng_done,
  output logic [3:0]                   out_idx,
  input  logic signed [DATA_WIDTH-1:0] eng_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [3:0]                   res_digit,
  output logic [DATA_WIDTH-1:0]        res_score,
  output logic [BATCH_W-1:0]           res_img
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENG_RST,
    S_ENG_START,
    S_WAIT_DONE,
    S_SCAN,
    S_EMIT
  } state_t;

  // Watchdog fires when the count would reach all-ones on this cycle.
  localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t                       r_state;
  logic [BATCH_W-1:0]           r_count;
  logic [BATCH_W-1:0]           r_img_idx;
  logic [TMO_W-1:0]             r_wdog;
  logic [3:0]                   r_out_idx;
  logic signed [DATA_WIDTH-1:0] r_best;
  logic [3:0]                   r_best_idx;
  logic                         r_eng_reset;
  logic                         r_eng_start;
  logic                         r_batch_done;
  logic                         r_err_timeout;
  logic                         r_res_valid;
  logic [3:0]                   r_res_digit;
  logic [DATA_WIDTH-1:0]        r_res_score;
  logic [BATCH_W-1:0]           r_res_img;

  logic                         w_take;
  logic                         w_last_img;
  logic signed [DATA_WIDTH-1:0] w_new_best;
  logic [3:0]                   w_new_idx;

  // Strictly-greater signed compare keeps the lower index on ties.
  always_comb begin
    w_take     = (r_out_idx == 4'd0) || (eng_out > r_best);
    w_new_best = w_take ? eng_out : r_best;
    w_new_idx  = w_take ? r_out_idx : r_best_idx;
    w_last_img = (r_img_idx == (r_count - 1'b1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_img_idx     <= '0;
      r_wdog        <= '0;
      r_out_idx     <= '0;
      r_best        <= '0;
      r_best_idx    <= '0;
      r_eng_reset   <= 1'b0;
      r_eng_start   <= 1'b0;
      r_batch_done  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_digit   <= '0;
      r_res_score   <= '0;
      r_res_img     <= '0;
    end else begin
      r_eng_reset  <= 1'b0;
      r_eng_start  <= 1'b0;
      r_batch_done <= 1'b0;
      if ((r_state != S_IDLE) && batch_abort) begin
        r_state      <= S_IDLE;
        r_eng_reset  <= 1'b1;
        r_batch_done <= 1'b1;
        r_res_valid  <= 1'b0;
        r_out_idx    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (batch_start) begin
              r_err_timeout <= 1'b0;
              if (batch_count == '0) begin
                r_batch_done <= 1'b1;
              end else begin
                r_count     <= batch_count;
                r_img_idx   <= '0;
                r_eng_reset <= 1'b1;
                r_state     <= S_ENG_RST;
              end
            end
          end
          S_ENG_RST: begin
            r_eng_start <= 1'b1;
            r_state     <= S_ENG_START;
          end
          S_ENG_START: begin
            r_wdog  <= '0;
            r_state <= S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            r_wdog <= r_wdog + 1'b1;
            if (eng_done) begin
              r_out_idx <= '0;
              r_state   <= S_SCAN;
            end else if (r_wdog == WDOG_LAST) begin
              r_err_timeout <= 1'b1;
              r_eng_reset   <= 1'b1;
              r_batch_done  <= 1'b1;
              r_state       <= S_IDLE;
            end
          end
          S_SCAN: begin
            r_best     <= w_new_best;
            r_best_idx <= w_new_idx;
            if (r_out_idx == 4'd9) begin
              r_out_idx   <= '0;
              r_res_digit <= w_new_idx;
              r_res_score <= w_new_best;
              r_res_img   <= r_img_idx;
              r_res_valid <= 1'b1;
              r_state     <= S_EMIT;
            end else begin
              r_out_idx <= r_out_idx + 1'b1;
            end
          end
          S_EMIT: begin
            if (res_ready) begin
              r_res_valid <= 1'b0;
              if (w_last_img) begin
                r_batch_done <= 1'b1;
                r_state      <= S_IDLE;
              end else begin
                r_img_idx   <= r_img_idx + 1'b1;
                r_eng_reset <= 1'b1;
                r_state     <= S_ENG_RST;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign batch_done  = r_batch_done;
  assign err_timeout = r_err_timeout;
  assign img_idx     = r_img_idx;
  assign eng_reset   = r_eng_reset;
  assign eng_start   = r_eng_start;
  assign out_idx     = r_out_idx;
  assign res_valid   = r_res_valid;
  assign res_digit   = r_res_digit;
  assign res_score   = r_res_score;
  assign res_img     = r_res_img;

endmodule

// File: tb/tb_dnn_batch_sched.sv
// Directed bench for dnn_batch_sched: table of single-image score sets plus
// hand-written stall, timeout, abort, zero-count and mid-batch reset sequences.
module tb_dnn_batch_sched;
  localparam int DW = 10;
  localparam int BW = 8;
  localparam int TW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              batch_start;
  logic [BW-1:0]     batch_count;
  logic              batch_abort;
  logic              busy;
  logic              batch_done;
  logic              err_timeout;
  logic [BW-1:0]     img_idx;
  logic              eng_reset;
  logic              eng_start;
  logic              eng_done;
  logic [3:0]        out_idx;
  logic signed [DW-1:0] eng_out;
  logic              res_valid;
  logic              res_ready;
  logic [3:0]        res_digit;
  logic [DW-1:0]     res_score;
  logic [BW-1:0]     res_img;

  dnn_batch_sched #(.DATA_WIDTH(DW), .BATCH_W(BW), .TMO_W(TW)) dut (
    .clk(clk), .rst(rst), .batch_start(batch_start), .batch_count(batch_count),
    .batch_abort(batch_abort), .busy(busy), .batch_done(batch_done),
    .err_timeout(err_timeout), .img_idx(img_idx), .eng_reset(eng_reset),
    .eng_start(eng_start), .eng_done(eng_done), .out_idx(out_idx), .eng_out(eng_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_digit(res_digit),
    .res_score(res_score), .res_img(res_img)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:9][DW-1:0] sc;
    logic [3:0]         dig;
    logic [DW-1:0]      best;
  } vec_t;

  vec_t               vecs [6];
  logic [0:9][DW-1:0] cur_sc;
  int                 done_delay;
  int                 tmr;
  int                 n_eng_rst = 0;
  int                 n_eng_start = 0;
  int                 n_bad_seq = 0;
  int                 n_xfer = 0;
  logic               prev_eng_rst = 1'b0;
  int                 n_vec = 0;
  int                 n_miss = 0;

  // Engine stand-in: scores are combinational from out_idx, done is a level.
  always_comb eng_out = (out_idx < 4'd10) ? cur_sc[out_idx] : '0;

  always @(posedge clk) begin
    if (!rst || eng_reset) begin
      tmr      <= -1;
      eng_done <= 1'b0;
    end else if (eng_start) begin
      tmr <= done_delay;
    end else if (tmr > 0) begin
      tmr <= tmr - 1;
      if (tmr == 1) eng_done <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      if (eng_reset) n_eng_rst <= n_eng_rst + 1;
      if (eng_start) begin
        n_eng_start <= n_eng_start + 1;
        if (!prev_eng_rst) n_bad_seq <= n_bad_seq + 1;
      end
      if (res_valid && res_ready && !batch_abort) n_xfer <= n_xfer + 1;
      prev_eng_rst <= eng_reset;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Leaves the bench at the negedge of the first cycle after acceptance.
  task automatic start_batch(input int cnt);
    batch_count = BW'(cnt);
    batch_start = 1'b1;
    @(negedge clk);
    batch_start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (res_valid !== 1'b1 && cyc < 200);
    if (res_valid !== 1'b1) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic wait_scan(input int img, input int k);
    int cyc;
    cyc = 0;
    while (!(busy && int'(img_idx) == img && int'(out_idx) == k) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 300) chk("wait_scan_timeout", 0, 1);
  endtask

  initial begin
    int cyc, r0, s0, x0, nv;
    logic [3:0] sd;
    logic [DW-1:0] ss;
    logic [BW-1:0] si;

    vecs[0].sc = '{-10'sd3, 10'sd7, 10'sd2, 10'sd7, 10'sd0, 10'h200, 10'sd1, 10'sd6, 10'sd5, 10'sd4};
    vecs[0].dig = 4'd1; vecs[0].best = 10'sd7;
    vecs[1].sc = '{10'h200, 10'h200, 10'h200, 10'h200, 10'h200, 10'h200, 10'h200, 10'h200, 10'h200, -10'sd1};
    vecs[1].dig = 4'd9; vecs[1].best = -10'sd1;
    vecs[2].sc = '0;
    vecs[2].dig = 4'd0; vecs[2].best = 10'sd0;
    vecs[3].sc = '{10'sd0, 10'sd1, 10'sd2, 10'sd3, 10'sd4, 10'sd511, 10'sd6, 10'sd7, 10'sd8, 10'sd9};
    vecs[3].dig = 4'd5; vecs[3].best = 10'sd511;
    vecs[4].sc = '{-10'sd9, -10'sd8, -10'sd7, -10'sd6, -10'sd5, -10'sd4, -10'sd3, -10'sd2, -10'sd1, 10'sd0};
    vecs[4].dig = 4'd9; vecs[4].best = 10'sd0;
    vecs[5].sc = '{10'sd100, 10'sd50, -10'sd1, 10'sd99, 10'sd0, 10'h200, 10'sd3, 10'sd100, 10'sd2, 10'sd1};
    vecs[5].dig = 4'd0; vecs[5].best = 10'sd100;

    rst = 1'b0; batch_start = 1'b0; batch_count = '0; batch_abort = 1'b0;
    res_ready = 1'b0; cur_sc = '0; done_delay = 5;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(batch_done), 0);
    chk("rst_eng_reset", int'(eng_reset), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single-image batches from the score table.
    for (int i = 0; i < 6; i++) begin
      cur_sc = vecs[i].sc; done_delay = 5; res_ready = 1'b1;
      s0 = n_eng_start;
      start_batch(1);
      chk("t_eng_reset_c1", int'(eng_reset), 1);
      chk("t_busy", int'(busy), 1);
      wait_valid(cyc);
      chk("t_latency", cyc + 1, 19);
      chk("t_digit", int'(res_digit), int'(vecs[i].dig));
      chk("t_score", int'($signed(res_score)), int'($signed(vecs[i].best)));
      chk("t_img", int'(res_img), 0);
      @(negedge clk);
      chk("t_batch_done", int'(batch_done), 1);
      chk("t_valid_low", int'(res_valid), 0);
      chk("t_idle", int'(busy), 0);
      chk("t_eng_starts", n_eng_start - s0, 1);
    end

    // Batch of 3 with 4-cycle stalls per result.
    cur_sc = vecs[0].sc; res_ready = 1'b0;
    r0 = n_eng_rst; s0 = n_eng_start;
    start_batch(3);
    for (int i = 0; i < 3; i++) begin
      wait_valid(cyc);
      chk("st_img", int'(res_img), i);
      chk("st_digit", int'(res_digit), 1);
      sd = res_digit; ss = res_score; si = res_img;
      repeat (3) begin
        @(negedge clk);
        chk("st_hold_valid", int'(res_valid), 1);
        chk("st_hold_digit", int'(res_digit), int'(sd));
        chk("st_hold_score", int'(res_score), int'(ss));
        chk("st_hold_img", int'(res_img), int'(si));
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("st_valid_drop", int'(res_valid), 0);
      if (i < 2) begin
        chk("st_next_rst", int'(eng_reset), 1);
        chk("st_next_img", int'(img_idx), i + 1);
      end else begin
        chk("st_done", int'(batch_done), 1);
        chk("st_idle", int'(busy), 0);
      end
    end
    chk("st_eng_starts", n_eng_start - s0, 3);
    chk("st_eng_resets", n_eng_rst - r0, 3);
    chk("st_start_after_rst", n_bad_seq, 0);

    // Watchdog timeout with the engine never finishing.
    done_delay = -1;
    start_batch(2);
    repeat (16) @(negedge clk);
    chk("to_not_yet", int'(err_timeout), 0);
    chk("to_busy", int'(busy), 1);
    @(negedge clk);
    chk("to_flag", int'(err_timeout), 1);
    chk("to_eng_reset", int'(eng_reset), 1);
    chk("to_batch_done", int'(batch_done), 1);
    chk("to_idle", int'(busy), 0);
    @(negedge clk);
    chk("to_sticky", int'(err_timeout), 1);
    chk("to_done_pulse", int'(batch_done), 0);

    // Zero-length batch also clears the sticky timeout flag.
    r0 = n_eng_rst; s0 = n_eng_start;
    start_batch(0);
    chk("z_done", int'(batch_done), 1);
    chk("z_tmo_clr", int'(err_timeout), 0);
    chk("z_busy", int'(busy), 0);
    @(negedge clk);
    chk("z_done_pulse", int'(batch_done), 0);
    chk("z_no_eng", (n_eng_rst - r0) + (n_eng_start - s0), 0);

    // Abort during the scan of image 1.
    done_delay = 5; res_ready = 1'b1; cur_sc = vecs[1].sc;
    x0 = n_xfer;
    start_batch(3);
    wait_scan(1, 4);
    batch_abort = 1'b1;
    @(negedge clk);
    batch_abort = 1'b0;
    chk("ab_busy", int'(busy), 0);
    chk("ab_eng_reset", int'(eng_reset), 1);
    chk("ab_done", int'(batch_done), 1);
    chk("ab_out_idx", int'(out_idx), 0);
    nv = 0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid) nv++;
    end
    chk("ab_no_valid", nv, 0);
    chk("ab_results", n_xfer - x0, 1);

    // Abort coincident with res_ready in EMIT takes the abort path.
    res_ready = 1'b0;
    start_batch(1);
    wait_valid(cyc);
    res_ready = 1'b1; batch_abort = 1'b1;
    @(negedge clk);
    res_ready = 1'b0; batch_abort = 1'b0;
    chk("abe_eng_reset", int'(eng_reset), 1);
    chk("abe_done", int'(batch_done), 1);
    chk("abe_valid", int'(res_valid), 0);

    // Abort in IDLE has no effect.
    @(negedge clk);
    batch_abort = 1'b1;
    @(negedge clk);
    batch_abort = 1'b0;
    chk("abi_done", int'(batch_done), 0);
    chk("abi_eng_reset", int'(eng_reset), 0);

    // Synchronous reset in the middle of image 1.
    res_ready = 1'b1;
    start_batch(3);
    wait_scan(1, 3);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_busy", int'(busy), 0);
    chk("mr_img_idx", int'(img_idx), 0);
    chk("mr_out_idx", int'(out_idx), 0);
    chk("mr_res_digit", int'(res_digit), 0);
    chk("mr_res_img", int'(res_img), 0);
    chk("mr_res_score", int'(res_score), 0);
    chk("mr_misc", int'({batch_done, err_timeout, eng_reset, eng_start, res_valid}), 0);
    rst = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/dnn_batch_sched.md
Name: dnn_batch_sched

Overview:
- Batch controller for the fix10 sigmoid inference engine and its output-select mux.
- Runs N images back-to-back:
  - Presents the image index to the memory subsystem.
  - Pulses the engine's reset, then its start, and waits for done.
  - Scans the 10 engine outputs through out_idx and computes the argmax digit.
  - Hands one result per image to a downstream consumer over a valid/ready handshake.
- Includes a done watchdog and an abort path.

Parameters:
- DATA_WIDTH, 10, width of the signed engine output score.
- BATCH_W, 8, width of the batch count and image index.
- TMO_W, 20, width of the watchdog counter; timeout occurs at 2^TMO_W-1 cycles in WAIT_DONE.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- batch_start  in  1  start pulse; accepted only in IDLE.
- batch_count  in  BATCH_W  number of images; sampled with batch_start.
- batch_abort  in  1  abort request; honoured in any state.
- busy  out  1  high in every state except IDLE.
- batch_done  out  1  one-cycle pulse when the batch completes or is aborted.
- err_timeout  out  1  sticky watchdog flag; cleared by an accepted batch_start.
- img_idx  out  BATCH_W  index of the current image, used by memory bank/offset select.
- eng_reset  out  1  engine reset pulse.
- eng_start  out  1  engine start pulse.
- eng_done  in  1  engine done level; held high until the next eng_reset.
- out_idx  out  4  engine output select.
- eng_out  in  DATA_WIDTH  signed score, combinational from out_idx.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer ready.
- res_digit  out  4  argmax digit, 0..9.
- res_score  out  DATA_WIDTH  winning score.
- res_img  out  BATCH_W  image index the result belongs to.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0; err_timeout is cleared.
  - Reset overrides all other inputs, including mid-batch.
- State sequence: IDLE -> ENG_RST -> ENG_START -> WAIT_DONE -> SCAN -> EMIT, then back to ENG_RST for the next image or to IDLE.
- IDLE:
  - batch_start with batch_count=0: batch_done pulses next cycle, no engine activity, err_timeout is cleared.
  - batch_start with batch_count>0: latch the count, set img_idx=0, clear err_timeout, go to ENG_RST.
- ENG_RST: eng_reset=1 for exactly 1 cycle, then ENG_START.
- ENG_START: eng_start=1 for exactly 1 cycle; clear the watchdog; then WAIT_DONE.
- WAIT_DONE:
  - Watchdog increments each cycle.
  - eng_done=1 goes to SCAN; minimum dwell is 1 cycle.
  - Watchdog reaching 2^TMO_W-1 with eng_done=0 triggers the timeout path:
    - err_timeout is set.
    - eng_reset pulses for 1 cycle.
    - batch_done pulses.
    - State returns to IDLE; remaining images are skipped.
- SCAN:
  - Exactly 10 cycles; out_idx = k = 0..9 on cycle k.
  - eng_out is sampled in the same cycle k.
  - Compare is signed. A candidate replaces the running best only if strictly greater, so ties keep the lower index.
  - Cycle 0 loads the best value unconditionally.
  - out_idx holds 0 outside SCAN.
- EMIT:
  - res_valid=1 with res_digit, res_score, res_img stable until res_ready=1.
  - Transfer happens on the cycle with res_valid&res_ready=1.
  - On transfer with images remaining: img_idx+1, go to ENG_RST.
  - On transfer after the last image: batch_done pulses and res_valid=0 in the same next cycle, go to IDLE.
- Result latency: first res_valid occurs 3 + W + 10 cycles after batch_start is accepted, where W = WAIT_DONE dwell.
- batch_abort (any non-IDLE state):
  - Next cycle: IDLE, eng_reset=1 for 1 cycle, batch_done pulse, res_valid=0.
  - An un-transferred result is dropped.
  - Abort and res_ready in the same EMIT cycle: abort wins and the result is not counted.
  - Abort in IDLE is ignored.
- batch_start while busy is ignored.
- img_idx holds its last value after the batch ends.
- batch_count=2^BATCH_W-1 is legal; no wrap occurs within a batch.

Test Plan:
- Single image: batch_count=1, eng_done rises 5 cycles after eng_start, eng_out per index = {-3,7,2,7,0,-512,1,6,5,4} -> res_digit=1, res_score=7 (tie with index 3 resolved low), res_img=0, batch_done 1 cycle after transfer.
- All-negative scores: -512 at all indices except index 9 = -1 -> res_digit=9, res_score=-1, exercising the signed compare.
- Batch of 3 with res_ready low for 4 cycles per result -> 3 results with res_img 0,1,2 in order; payload stable while stalled; exactly 3 eng_start pulses, each preceded by eng_reset.
- Timeout: TMO_W=4, eng_done never asserted -> err_timeout=1 after 15 WAIT_DONE cycles, eng_reset pulse, batch_done pulse, IDLE; next batch_start clears err_timeout.
- Abort during SCAN at out_idx=4 of image 1 of a 3-image batch -> IDLE next cycle, eng_reset and batch_done pulses, no res_valid for image 1, busy=0.
- batch_count=0 -> batch_done 1 cycle later with no eng_reset/eng_start; mid-batch rst=0 -> all outputs 0 the next cycle.
